// File: rtl/flow_dispatcher_pkg.sv
// Shared types for the flow dispatcher: FSM state encoding and word-index width helper.
// Pure declarations, no logic; imported by the interface, the lane and the top.
// No flow control lives here.
package flow_dispatcher_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

    // Width of a word index; a single-word bundle still gets one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/flow_dispatcher_if.sv
// Bundle-in / multi-lane-out bus of the flow dispatcher.
// master = upstream producer plus downstream lane consumers, slave = the dispatcher.
// valid_in/ready upstream, valid_out/ready_in per lane downstream.
interface flow_dispatcher_if
    import flow_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 3,
    parameter int LANES      = 3
) ();

    localparam int IDX_W = idx_width(WORDS);

    logic [DATA_WIDTH-1:0] din       [WORDS];
    logic                  valid_in;
    logic                  ready;
    logic [DATA_WIDTH-1:0] dout      [LANES];
    logic [IDX_W-1:0]      idx_out   [LANES];
    logic [LANES-1:0]      valid_out;
    logic [LANES-1:0]      ready_in;
    logic                  busy;

    modport master (
        output din, valid_in, ready_in,
        input  ready, dout, idx_out, valid_out, busy
    );

    modport slave (
        input  din, valid_in, ready_in,
        output ready, dout, idx_out, valid_out, busy
    );

endinterface

// File: rtl/flow_dispatch_lane.sv
// One dispatch lane: walks word indices LANE_ID, LANE_ID+LANES, ... of the held bundle.
// Word select is combinational from the pointer register; the pointer steps one edge after a handshake.
// Holds dout/idx_out stable while ready_in is low.
module flow_dispatch_lane
    import flow_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 3,
    parameter int LANES      = 3,
    parameter int LANE_ID    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         active,
    input  logic [WORDS-1:0]             pending,
    input  logic [DATA_WIDTH-1:0]        bundle [WORDS],
    input  logic                         ready_in,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [idx_width(WORDS)-1:0]  idx_out,
    output logic                         valid_out,
    output logic                         hs
);

    localparam int IDX_W = idx_width(WORDS);
    // Step and start are clamped to WORDS so the IDX_W+1 bit pointer never wraps,
    // even when LANES is much larger than WORDS.
    localparam int STEP = (LANES > WORDS) ? WORDS : LANES;
    localparam int INIT = (LANE_ID < WORDS) ? LANE_ID : WORDS;

    localparam logic [IDX_W:0] STEP_P  = STEP[IDX_W:0];
    localparam logic [IDX_W:0] INIT_P  = INIT[IDX_W:0];
    localparam logic [IDX_W:0] WORDS_P = WORDS[IDX_W:0];

    logic [IDX_W:0]   p;
    logic [IDX_W-1:0] sel;
    logic             in_range;

    assign sel       = p[IDX_W-1:0];
    assign in_range  = (p < WORDS_P);
    assign valid_out = active && in_range && pending[sel];
    assign hs        = valid_out && ready_in;
    assign dout      = in_range ? bundle[sel] : '0;
    assign idx_out   = in_range ? sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (load) begin
            p <= INIT_P;
        end else if (hs) begin
            p <= p + STEP_P;
        end
    end

endmodule

// File: rtl/flow_dispatcher.sv
// Captures a WORDS-word bundle and spreads it over LANES lanes; FLOW_DISPATCHER_BACK2BACK_EN removes the inter-bundle bubble.
// First words appear one cycle after capture; ceil(WORDS/LANES) dispatch cycles with all lanes ready.
// ready drops while a bundle is held (or, back-to-back, until the last pending words handshake).
module flow_dispatcher
    import flow_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 3,
    parameter int LANES      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    flow_dispatcher_if.slave        bus
);

    localparam int IDX_W = idx_width(WORDS);

    state_t                state;
    logic [DATA_WIDTH-1:0] bundle    [WORDS];
    logic [WORDS-1:0]      pending;
    logic [WORDS-1:0]      clear;
    logic [WORDS-1:0]      pending_nxt;
    logic [LANES-1:0]      hs;
    logic [LANES-1:0]      lane_vld;
    logic [IDX_W-1:0]      lane_idx  [LANES];
    logic [DATA_WIDTH-1:0] lane_dout [LANES];
    logic                  active;
    logic                  accept;

    assign active = (state == DISPATCH);

    // Lanes own disjoint index sets, so at most one lane clears any given bit.
    always_comb begin
        clear = '0;
        for (int l = 0; l < LANES; l++) begin
            if (hs[l]) begin
                clear[lane_idx[l]] = 1'b1;
            end
        end
    end

    assign pending_nxt = pending & ~clear;

`ifdef FLOW_DISPATCHER_BACK2BACK_EN
    assign bus.ready = !active || (pending_nxt == '0);
`else
    assign bus.ready = !active;
`endif

    assign accept = bus.valid_in && bus.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            for (int w = 0; w < WORDS; w++) begin
                bundle[w] <= '0;
            end
        end else if (accept) begin
            state   <= DISPATCH;
            pending <= '1;
            for (int w = 0; w < WORDS; w++) begin
                bundle[w] <= bus.din[w];
            end
        end else if (active) begin
            pending <= pending_nxt;
            if (pending_nxt == '0) begin
                state <= IDLE;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        flow_dispatch_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .WORDS      (WORDS),
            .LANES      (LANES),
            .LANE_ID    (l)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (accept),
            .active     (active),
            .pending    (pending),
            .bundle     (bundle),
            .ready_in   (bus.ready_in[l]),
            .dout       (lane_dout[l]),
            .idx_out    (lane_idx[l]),
            .valid_out  (lane_vld[l]),
            .hs         (hs[l])
        );
    end

    assign bus.dout      = lane_dout;
    assign bus.idx_out   = lane_idx;
    assign bus.valid_out = lane_vld;
    assign bus.busy      = active;

endmodule

// File: doc/flow_dispatcher.md
FLOW_DISPATCHER -- requirements
Module: flow_dispatcher

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, width of each data word.
- REQ-002: Parameter WORDS, default 3, number of words per bundle (≥1).
- REQ-003: Parameter LANES, default 3, number of downstream lanes (≥1).
- REQ-004: Localparam IDX_W SHALL equal max(1, $clog2(WORDS)), the width of a word index.
- REQ-005: Port clk, input, 1, the single clock; all state SHALL be on its rising edge.
- REQ-006: Port rst_n, input, 1, asynchronous active-low reset.
- REQ-007: Port din, input, WORDS x DATA_WIDTH unpacked array, the bundle words.
- REQ-008: Port valid_in, input, 1, din holds a bundle.
- REQ-009: Port ready, output, 1, the block accepts a bundle this cycle.
- REQ-010: Port dout, output, LANES x DATA_WIDTH unpacked array, the word presented on each lane.
- REQ-011: Port idx_out, output, LANES x IDX_W unpacked array, the bundle index of the word on each lane.
- REQ-012: Port valid_out, output, LANES, a lane presents a word.
- REQ-013: Port ready_in, input, LANES, the downstream consumer of each lane accepts.
- REQ-014: Port busy, output, 1, a bundle is held with words still pending.

Function
- REQ-015: The block SHALL implement states IDLE and DISPATCH.
- REQ-016: In IDLE, ready SHALL be 1, busy 0 and valid_out all 0.
- REQ-017: A cycle with valid_in && ready SHALL capture all din words, set the pending mask to all ones, set each lane pointer p[l] = l, and enter DISPATCH on the next cycle.
- REQ-018: Lane l SHALL serve word indices l, l+LANES, l+2·LANES, … below WORDS, in ascending order; a lane with l ≥ WORDS SHALL never assert valid_out.
- REQ-019: In DISPATCH, valid_out[l] SHALL be 1 iff p[l] < WORDS and pending[p[l]] is 1.
- REQ-020: While valid_out[l] is 1, dout[l] and idx_out[l] SHALL equal the captured word p[l] and the value p[l], held stable until the handshake.
- REQ-021: A handshake (valid_out[l] && ready_in[l]) SHALL clear pending[p[l]] and advance p[l] by LANES on the next edge.
- REQ-022: Several lanes SHALL be able to handshake in the same cycle, so dispatch latency is ceil(WORDS/LANES) cycles with all ready_in held high.
- REQ-023: When the pending mask becomes all zero, the block SHALL return to IDLE on the next edge.
- REQ-024: Without the REQ-031 feature, ready SHALL be 0 throughout DISPATCH, leaving one IDLE bubble cycle between bundles.
- REQ-025: busy SHALL equal (state == DISPATCH).
- REQ-026: valid_in while ready is 0 SHALL be ignored; the upstream holds din.
- REQ-027: Pointer arithmetic SHALL be performed at IDX_W+1 bits, so p[l] + LANES does not wrap.

Reset
- REQ-028: Assertion of rst_n low SHALL, asynchronously, force IDLE, clear the pending mask, clear the pointers and zero the bundle register.
- REQ-029: Reset values SHALL be: ready = 1 once reset is released, valid_out = 0, busy = 0, dout = 0, idx_out = 0.
- REQ-030: A reset asserted during DISPATCH SHALL drop the held bundle without completing any further handshake.

Configuration
- REQ-031: With FLOW_DISPATCHER_BACK2BACK_EN defined, ready SHALL also be 1 in DISPATCH in any cycle where every still-pending word handshakes.
- REQ-032: Under FLOW_DISPATCHER_BACK2BACK_EN, ready SHALL be a combinational function of ready_in.
- REQ-033: Under FLOW_DISPATCHER_BACK2BACK_EN, valid_in in such a cycle SHALL load the new bundle and remain in DISPATCH with no bubble.
- REQ-034: Without FLOW_DISPATCHER_BACK2BACK_EN, ready SHALL depend only on registered state.

Structure
- REQ-035: The shared flow package SHALL hold the state enum (IDLE, DISPATCH) and the index-width helper function.
- REQ-036: One sub-module, flow_dispatch_lane, SHALL hold the pointer register, word select and handshake for one lane.
- REQ-037: flow_dispatch_lane SHALL be instantiated LANES times by a generate loop.

Verification
- REQ-038: Defaults, din = {0xC,0xB,0xA}, valid_in = 1, all ready_in = 1 -> next cycle lanes 0..2 show 0xA/0xB/0xC, idx 0/1/2, valid_out = 3'b111; following cycle IDLE, ready = 1.
- REQ-039: WORDS = 5, LANES = 2, all ready_in = 1 -> lane 0 emits idx 0, 2, 4 and lane 1 emits idx 1, 3; busy is high for exactly 3 cycles.
- REQ-040: Defaults, ready_in[1] = 0 for 4 cycles -> lane 1 holds word 1 stable with valid_out[1] = 1, ready stays 0, and the return to IDLE follows the first ready_in[1] = 1.
- REQ-041: Defaults, rst_n pulsed low mid-DISPATCH -> valid_out = 0 immediately (asynchronously), busy = 0, and the next bundle is accepted normally.
- REQ-042: With FLOW_DISPATCHER_BACK2BACK_EN, two bundles presented back to back with all ready_in = 1 -> valid_out = 3'b111 on consecutive cycles with no gap; without the macro, a one-cycle gap.
